// File: rtl/risc_pkg.sv
// Shared pipeline constants and the LM/SM sequencer state type.
package risc_pkg;
  localparam int REG_IDX_W = 3;
  localparam int WORD_W    = 16;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} seq_state_t;
endpackage

// File: rtl/lmsm_sequencer_if.sv
// Decode-side request bus and RR-side micro-op bus of the LM/SM sequencer.
// master = surrounding pipeline, slave = sequencer.
interface lmsm_sequencer_if #(
  parameter int LIST_W = 8,
  parameter int RIDX_W = 3,
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_is_load;
  logic [LIST_W-1:0] in_list;
  logic [ADDR_W-1:0] in_base;
  logic              in_ready;
  logic              flush;
  logic              uop_valid;
  logic              uop_ready;
  logic              uop_is_load;
  logic [RIDX_W-1:0] uop_reg;
  logic [ADDR_W-1:0] uop_addr;
  logic              uop_last;
  logic              stall_fetch;

  modport master (
    output in_valid, in_is_load, in_list, in_base, flush, uop_ready,
    input  in_ready, uop_valid, uop_is_load, uop_reg, uop_addr, uop_last, stall_fetch
  );

  modport slave (
    input  in_valid, in_is_load, in_list, in_base, flush, uop_ready,
    output in_ready, uop_valid, uop_is_load, uop_reg, uop_addr, uop_last, stall_fetch
  );
endinterface

// File: rtl/lsb_prienc.sv
// Lowest-set-bit finder: index and one-hot mask of the lowest 1 in i_list.
// All-zero input yields index 0 and an empty mask.
module lsb_prienc #(
  parameter int LIST_W = 8,
  parameter int RIDX_W = 3
) (
  input  logic [LIST_W-1:0] i_list,
  output logic [RIDX_W-1:0] o_idx,
  output logic [LIST_W-1:0] o_onehot
);
  // two's-complement trick isolates the lowest set bit
  assign o_onehot = i_list & (~i_list + LIST_W'(1));

  // encode the (at most one) set bit of the mask
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < LIST_W; k++)
      if (o_onehot[k]) o_idx = o_idx | RIDX_W'(k);
  end
endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: expands one decoded LM/SM into one memory micro-op per
// set bit of the register list, ascending register order, while stalling
// fetch. Optional statistics counters are enabled by LMSM_STATS_EN.
module lmsm_sequencer
  import risc_pkg::*;
#(
  parameter int LIST_W = 8,
  parameter int RIDX_W = REG_IDX_W,
  parameter int ADDR_W = WORD_W
) (
  input  logic clk,
  input  logic resetn,
  lmsm_sequencer_if.slave bus
`ifdef LMSM_STATS_EN
  ,
  output logic [15:0] stat_uops,
  output logic [15:0] stat_stall
`endif
);
  seq_state_t        r_state, w_state_nxt;
  logic [LIST_W-1:0] r_list;      // remaining list, including the presented uop
  logic [LIST_W-1:0] r_mask;      // one-hot of the presented uop's register
  logic [RIDX_W:0]   r_cnt;       // micro-ops accepted so far
  logic [ADDR_W-1:0] r_base;
  logic              r_is_load;
  logic              r_uop_valid, r_uop_last, r_uop_is_load;
  logic [RIDX_W-1:0] r_uop_reg;
  logic [ADDR_W-1:0] r_uop_addr;

  logic              w_accept, w_xfer, w_in_ready, w_stall, w_last;
  logic [LIST_W-1:0] w_src, w_onehot;
  logic [RIDX_W-1:0] w_idx;
  logic [RIDX_W:0]   w_cnt_nxt;

  assign w_accept  = (r_state == IDLE) & bus.in_valid & ~bus.flush & (|bus.in_list);
  assign w_xfer    = r_uop_valid & bus.uop_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;

  // list the next micro-op is picked from: fresh list on accept, else drop consumed bit
  assign w_src  = (r_state == IDLE) ? bus.in_list : (r_list & ~r_mask);
  assign w_last = ((w_src & ~w_onehot) == '0);

  lsb_prienc #(.LIST_W(LIST_W), .RIDX_W(RIDX_W)) u_prienc (
    .i_list   (w_src),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // next state, handshake and fetch stall
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_stall    = w_accept;  // hold the instruction behind the LM/SM now
        if (w_accept) w_state_nxt = SEQ;
      end
      SEQ: begin
        w_stall = 1'b1;
        if (bus.flush || (w_xfer && r_uop_last)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // sequence bookkeeping and registered micro-op outputs; flush has priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_list <= '0; r_mask <= '0; r_cnt <= '0; r_base <= '0; r_is_load <= 1'b0;
      r_uop_valid <= 1'b0; r_uop_last <= 1'b0; r_uop_is_load <= 1'b0;
      r_uop_reg <= '0; r_uop_addr <= '0;
    end else if (bus.flush) begin
      r_list <= '0; r_mask <= '0; r_cnt <= '0;
      r_uop_valid <= 1'b0; r_uop_last <= 1'b0;
    end else if (w_accept) begin
      r_list        <= bus.in_list;
      r_mask        <= w_onehot;
      r_cnt         <= '0;
      r_base        <= bus.in_base;
      r_is_load     <= bus.in_is_load;
      r_uop_valid   <= 1'b1;
      r_uop_is_load <= bus.in_is_load;
      r_uop_reg     <= w_idx;
      r_uop_addr    <= bus.in_base;
      r_uop_last    <= w_last;
    end else if (w_xfer) begin
      if (r_uop_last) begin
        r_list <= '0; r_mask <= '0; r_cnt <= '0;
        r_uop_valid <= 1'b0; r_uop_last <= 1'b0;
      end else begin
        r_list        <= w_src;
        r_mask        <= w_onehot;
        r_cnt         <= w_cnt_nxt;
        r_uop_is_load <= r_is_load;
        r_uop_reg     <= w_idx;
        r_uop_addr    <= r_base + ADDR_W'(w_cnt_nxt);  // wraps mod 2^ADDR_W
        r_uop_last    <= w_last;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.stall_fetch = w_stall;
  assign bus.uop_valid   = r_uop_valid;
  assign bus.uop_is_load = r_uop_is_load;
  assign bus.uop_reg     = r_uop_reg;
  assign bus.uop_addr    = r_uop_addr;
  assign bus.uop_last    = r_uop_last;

`ifdef LMSM_STATS_EN
  logic [15:0] r_stat_uops, r_stat_stall;

  // saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_uops  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_xfer  && (r_stat_uops  != 16'hFFFF)) r_stat_uops  <= r_stat_uops  + 16'd1;
      if (w_stall && (r_stat_stall != 16'hFFFF)) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_uops  = r_stat_uops;
  assign stat_stall = r_stat_stall;
`endif
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer with a micro-op scoreboard.
module tb_lmsm_sequencer;
  typedef struct packed {
    logic        is_load;
    logic [2:0]  rg;
    logic [15:0] addr;
    logic        last;
  } uop_t;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_stall  = 0;
  int   n_seen   = 0;
  uop_t q[$];

`ifdef LMSM_STATS_EN
  logic [15:0] stat_uops, stat_stall;
`endif

  lmsm_sequencer_if bus ();

  lmsm_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef LMSM_STATS_EN
    ,
    .stat_uops  (stat_uops),
    .stat_stall (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected micro-ops for one LM/SM, built from the list bit by bit
  task automatic push_expect(input logic ld, input logic [7:0] list, input logic [15:0] base);
    int total;
    int c;
    uop_t u;
    total = $countones(list);
    c = 0;
    for (int k = 0; k < 8; k++) begin
      if (list[k]) begin
        u.is_load = ld;
        u.rg      = 3'(k);
        u.addr    = base + 16'(c);
        u.last    = (c == total - 1);
        q.push_back(u);
        c++;
      end
    end
  endtask

  // drive one LM/SM for a single cycle; returns with the first uop presented
  task automatic start(input logic ld, input logic [7:0] list, input logic [15:0] base);
    @(posedge clk); #1;
    n_stall = 0;
    n_seen  = 0;
    push_expect(ld, list, base);
    bus.in_valid   = 1'b1;
    bus.in_is_load = ld;
    bus.in_list    = list;
    bus.in_base    = base;
    #1;
    check("accept_in_ready", 32'(bus.in_ready), 32'd1);
    check("accept_stall", 32'(bus.stall_fetch), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("seq_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.stall_fetch && !bus.uop_valid) break;
    end
    check(tag, 32'(bus.stall_fetch | bus.uop_valid), 32'd0);
    check({tag, "_sb_drained"}, 32'(q.size()), 32'd0);
  endtask

  // scoreboard: every transfer must match the next expected micro-op
  always @(negedge clk) begin
    uop_t e;
    if (bus.stall_fetch) n_stall++;
    if (resetn && bus.uop_valid && bus.uop_ready) begin
      n_seen++;
      if (q.size() == 0) check("uop_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("uop", 32'({bus.uop_is_load, bus.uop_reg, bus.uop_addr, bus.uop_last}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.in_valid = 1'b0; bus.in_is_load = 1'b0; bus.in_list = '0; bus.in_base = '0;
    bus.flush = 1'b0; bus.uop_ready = 1'b1;
    #1;
    check("rst_uop_valid", 32'(bus.uop_valid), 32'd0);
    check("rst_uop_addr", 32'(bus.uop_addr), 32'd0);
    check("rst_stall", 32'(bus.stall_fetch), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // LM, sparse list, full throughput
    start(1'b1, 8'b1010_0100, 16'h0040);
    wait_idle("lm_sparse_idle");
    check("lm_sparse_uops", 32'(n_seen), 32'd3);
    check("lm_sparse_stall_cycles", 32'(n_stall), 32'd4);
`ifdef LMSM_STATS_EN
    check("stat_uops", 32'(stat_uops), 32'd3);
    check("stat_stall", 32'(stat_stall), 32'd4);
`endif

    // SM, full list, address wrap
    start(1'b0, 8'hFF, 16'hFFFE);
    wait_idle("sm_full_idle");
    check("sm_full_uops", 32'(n_seen), 32'd8);
    check("sm_full_stall_cycles", 32'(n_stall), 32'd9);

    // backpressure on the first micro-op
    bus.uop_ready = 1'b0;
    start(1'b1, 8'b0000_0011, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.uop_valid), 32'd1);
      check("bp_reg", 32'(bus.uop_reg), 32'd0);
      check("bp_addr", 32'(bus.uop_addr), 32'h1234);
      check("bp_stall", 32'(bus.stall_fetch), 32'd1);
    end
    @(posedge clk); #1;
    bus.uop_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_reg", 32'(bus.uop_reg), 32'd1);
    check("bp_next_valid", 32'(bus.uop_valid), 32'd1);
    wait_idle("bp_idle");
    check("bp_uops", 32'(n_seen), 32'd2);

    // flush while the second of four micro-ops is presented
    start(1'b1, 8'b0101_0101, 16'h0100);
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    q.delete();
    check("flush_uop_valid", 32'(bus.uop_valid), 32'd0);
    check("flush_stall", 32'(bus.stall_fetch), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_uops_before", 32'(n_seen), 32'd2);
    start(1'b1, 8'b1000_0010, 16'h0200);
    wait_idle("post_flush_idle");
    check("post_flush_uops", 32'(n_seen), 32'd2);

    // flush beats a request in IDLE
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_list = 8'h0F; bus.flush = 1'b1;
    #1 check("flush_idle_stall", 32'(bus.stall_fetch), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    check("flush_idle_no_uop", 32'(bus.uop_valid), 32'd0);
    check("flush_idle_in_ready", 32'(bus.in_ready), 32'd1);

    // empty list is a NOP
    @(posedge clk); #1;
    n_stall = 0;
    bus.in_valid = 1'b1; bus.in_list = 8'h00; bus.in_is_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("empty_stall", 32'(bus.stall_fetch), 32'd0);
      @(posedge clk); #1;
      check("empty_no_uop", 32'(bus.uop_valid), 32'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("empty_stall_cycles", 32'(n_stall), 32'd0);

    // async reset mid-sequence
    start(1'b1, 8'hFF, 16'h0300);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check("arst_uop_valid", 32'(bus.uop_valid), 32'd0);
    check("arst_uop_reg", 32'(bus.uop_reg), 32'd0);
    check("arst_uop_addr", 32'(bus.uop_addr), 32'd0);
    check("arst_uop_last", 32'(bus.uop_last), 32'd0);
    check("arst_stall", 32'(bus.stall_fetch), 32'd0);
    q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("arst_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_release_valid", 32'(bus.uop_valid), 32'd0);
    start(1'b0, 8'b0000_0001, 16'h0005);
    wait_idle("post_reset_idle");
    check("post_reset_uops", 32'(n_seen), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
